tqvp_spi_multi_bridge: RTL

SPI-to-register bridge for the TinyQV peripheral test harness, generalised from a single peripheral to NUM_PERIPH peripheral slots. It decodes SPI mode-0 frames and routes each transaction by address to one slot, issuing TinyQV-style byte/half/word write and read strobes. Reads are held until the selected slot's data_ready, then streamed back on MISO behind a start bit, so the SPI master can poll variable-latency peripherals. Sits between the TT pins and the peripheral instances; replaces the single-peripheral SPI wiring in the top level.

---
 rtl/tqvp_spi_multi_bridge.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tqvp_spi_multi_bridge.sv
// SPI mode-0 to TinyQV register bridge routing each frame to one of NUM_PERIPH slots.
// Optional read timeout enabled by defining BRIDGE_TIMEOUT_EN.
module tqvp_spi_multi_bridge #(
    parameter int NUM_PERIPH     = 4,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_cs_n,
    input  logic                       spi_clk,
    input  logic                       spi_mosi,
    output logic                       spi_miso,
    output logic [NUM_PERIPH-1:0]      periph_sel,
    output logic [ADDR_W-1:0]          periph_address,
    output logic [31:0]                data_in,
    output logic [1:0]                 data_write_n,
    output logic [1:0]                 data_read_n,
    input  logic [32*NUM_PERIPH-1:0]   data_out,
    input  logic [NUM_PERIPH-1:0]      data_ready,
    input  logic [NUM_PERIPH-1:0]      user_interrupt,
    output logic                       irq_out,
    output logic                       busy,
    output logic                       timeout_pulse
);
    localparam int SEL_W = $clog2(NUM_PERIPH);
    localparam int HDR_W = SEL_W + ADDR_W;
    localparam logic [SEL_W:0] NP = (SEL_W+1)'(NUM_PERIPH);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WSTROBE, S_RWAIT, S_RDATA, S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        cs_sync, clk_sync, mosi_sync;
    logic              clk_d;
    logic              cs_s, mosi_s, rise, fall;
    logic [30:0]       sh;
    logic [31:0]       sh_nxt;
    logic [SEL_W-1:0]  hdr_sel;
    logic [SEL_W-1:0]  sel_r;
    logic [5:0]        bit_cnt;
    logic              rw_r;
    logic [1:0]        width_r;
    logic [31:0]       tx;
    logic              started;
    logic [31:0]       slot_data;
`ifdef BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]   to_cnt;
`endif

    function automatic logic [1:0] norm_w(input logic [1:0] w);
        return (w == 2'b11) ? 2'b10 : w;
    endfunction

    function automatic logic [5:0] last_bit(input logic [1:0] w);
        case (w)
            2'b00:   return 6'd7;
            2'b01:   return 6'd15;
            default: return 6'd31;
        endcase
    endfunction

    function automatic logic [31:0] mask_w(input logic [31:0] v, input logic [1:0] w);
        case (w)
            2'b00:   return {24'b0, v[7:0]};
            2'b01:   return {16'b0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Left-aligns the response so MISO always shifts out of bit 31.
    function automatic logic [31:0] align_w(input logic [31:0] v, input logic [1:0] w);
        case (w)
            2'b00:   return {v[7:0], 24'b0};
            2'b01:   return {v[15:0], 16'b0};
            default: return v;
        endcase
    endfunction

    function automatic logic sel_ok(input logic [SEL_W-1:0] s);
        return ({1'b0, s} < NP);
    endfunction

    function automatic logic [NUM_PERIPH-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [NUM_PERIPH-1:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign rise      = clk_sync[1] & ~clk_d;
    assign fall      = ~clk_sync[1] & clk_d;
    assign sh_nxt    = {sh, mosi_s};
    assign hdr_sel   = sh_nxt[HDR_W-1:ADDR_W];
    assign slot_data = data_out[int'(sel_r)*32 +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= 2'b11;
            clk_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            clk_d     <= 1'b0;
            irq_out   <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs_n};
            clk_sync  <= {clk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            clk_d     <= clk_sync[1];
            irq_out   <= |user_interrupt;
        end
    end

    // Frame shift register; every field is sliced out of it at its last bit.
    always_ff @(posedge clk) begin
        if (rise) sh <= sh_nxt[30:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bit_cnt        <= '0;
            rw_r           <= 1'b0;
            width_r        <= 2'b00;
            sel_r          <= '0;
            tx             <= '0;
            started        <= 1'b0;
            spi_miso       <= 1'b0;
            periph_sel     <= '0;
            periph_address <= '0;
            data_in        <= '0;
            data_write_n   <= 2'b11;
            data_read_n    <= 2'b11;
            busy           <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            to_cnt         <= '0;
            timeout_pulse  <= 1'b0;
`endif
        end else begin
`ifdef BRIDGE_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            if (state != S_IDLE && cs_s) begin
                state        <= S_IDLE;
                busy         <= 1'b0;
                data_write_n <= 2'b11;
                data_read_n  <= 2'b11;
                periph_sel   <= '0;
                spi_miso     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        spi_miso <= 1'b0;
                        if (!cs_s) begin
                            state   <= S_CMD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    S_CMD: if (rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd2) begin
                            rw_r    <= sh[1];
                            width_r <= norm_w(sh_nxt[1:0]);
                            bit_cnt <= '0;
                            state   <= S_ADDR;
                        end
                    end
                    S_ADDR: if (rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'(HDR_W - 1)) begin
                            bit_cnt        <= '0;
                            sel_r          <= hdr_sel;
                            periph_address <= sh_nxt[ADDR_W-1:0];
                            started        <= 1'b0;
                            if (rw_r) begin
                                state <= S_WDATA;
                            end else if (sel_ok(hdr_sel)) begin
                                state       <= S_RWAIT;
                                data_read_n <= width_r;
                                periph_sel  <= onehot(hdr_sel);
`ifdef BRIDGE_TIMEOUT_EN
                                to_cnt      <= '0;
`endif
                            end else begin
                                // Unmapped slot: answer immediately with zero data.
                                state <= S_RDATA;
                                tx    <= '0;
                            end
                        end
                    end
                    S_WDATA: if (rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == last_bit(width_r)) begin
                            data_in <= mask_w(sh_nxt, width_r);
                            if (sel_ok(sel_r)) begin
                                state        <= S_WSTROBE;
                                data_write_n <= width_r;
                                periph_sel   <= onehot(sel_r);
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                    S_WSTROBE: begin
                        data_write_n <= 2'b11;
                        periph_sel   <= '0;
                        state        <= S_DONE;
                    end
                    S_RWAIT: begin
                        if (data_ready[sel_r]) begin
                            tx          <= align_w(slot_data, width_r);
                            data_read_n <= 2'b11;
                            periph_sel  <= '0;
                            bit_cnt     <= '0;
                            state       <= S_RDATA;
                        end
`ifdef BRIDGE_TIMEOUT_EN
                        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            tx            <= align_w('1, width_r);
                            data_read_n   <= 2'b11;
                            periph_sel    <= '0;
                            bit_cnt       <= '0;
                            timeout_pulse <= 1'b1;
                            state         <= S_RDATA;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
`endif
                    end
                    S_RDATA: if (fall) begin
                        if (!started) begin
                            spi_miso <= 1'b1;
                            started  <= 1'b1;
                        end else begin
                            spi_miso <= tx[31];
                            tx       <= {tx[30:0], 1'b0};
                            bit_cnt  <= bit_cnt + 6'd1;
                            if (bit_cnt == last_bit(width_r)) state <= S_DONE;
                        end
                    end
                    S_DONE: if (fall) spi_miso <= 1'b0;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifndef BRIDGE_TIMEOUT_EN
    // No timeout hardware in this build; the parameter only keeps the interface uniform.
    assign timeout_pulse = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule
